pcs_tx_gearbox: RTL
===================

# pcs_tx_gearbox

Transmit gearbox for the 10GBASE-R PCS, placed directly downstream of the 32-bit scrambler and upstream of the transceiver TX data port. It packs 2-bit sync headers and 32-bit scrambled words into a continuous 32-bit serial-order stream, using a 66-bits-in / 64-bits-out schedule. It throttles the upstream path with a one-slot pause every 33 cycles.

## Interface
- DATA_WIDTH, 32: input and output word width; only 32 is supported.
- TRDY_LEAD, 2: cycles between `o_tx_trdy` and the matching input slot, covering the upstream registered handshake stages.
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, synchronous, active-low; clock i_clk.
- i_rx_data  in  32  scrambled payload word; bit 0 is oldest on the line.
- i_rx_hdr  in  2  sync header; sampled only on the first word of a block.
- i_rx_data_valid  in  1  the word in `i_rx_data` is valid this cycle.
- o_tx_trdy  out  1  low marks the pause slot TRDY_LEAD cycles ahead.
- o_tx_data  out  32  packed line word; bit 0 is transmitted first.
- o_tx_data_valid  out  1  `o_tx_data` holds 32 real bits.
- o_slip_err  out  1  one-cycle pulse: input was valid in a pause slot.
- o_underrun  out  1  one-cycle pulse: fewer than 32 bits were buffered at output time.
- o_hdr_err  out  1  one-cycle pulse: header at block start was neither 01 nor 10.

## Operation
- **Slot counter.** `seq` runs freely 0..32 and wraps to 0.
  - `seq == 32` is the pause slot; every other value is a data slot.
  - `o_tx_trdy` is registered and low exactly when `seq` will equal 32 in TRDY_LEAD cycles.
- **Phase bit.** `phase` toggles on every accepted word.
  - Phase 0 accepts 34 bits: `{i_rx_data, i_rx_hdr}`, with header bit 0 oldest.
  - Phase 1 accepts 32 bits: `i_rx_data` only.
- **Buffer.** Shift buffer of at least 96 bits with a `count` field of 7 bits.
  - New bits are appended at bit position `count`.
  - Each cycle with `count >= 32`, bits [31:0] are output, the buffer shifts right by 32, and `count` drops by 32.
  - The append and the drain in one cycle combine, so net `count` = count + in − out.
- **Pause slot.** A valid word in the pause slot is dropped and raises `o_slip_err`; `phase` does not toggle.
- **Missing word.** A data slot without valid appends nothing; `phase` holds.
- **Underrun.** If `count < 32` at output time: `o_tx_data_valid` = 0, `o_tx_data` holds its previous value, buffer untouched, and `o_underrun` pulses. The pulse is suppressed until the first word after reset has been accepted.
- **Header check.** `o_hdr_err` pulses when a phase-0 word carries a header of 00 or 11. The word is still transmitted unchanged.
- **Steady state.** 16 blocks = 32 input words = 1056 bits = 33 output words, so `count` returns to its start value every frame.

## Timing
- **Reset values:**
  - `seq` = 0, `phase` = 0, `count` = 0, buffer cleared.
  - `o_tx_data` = 0, `o_tx_data_valid` = 0, `o_tx_trdy` = 1.
  - All error pulses 0.
- **Latency.** A word accepted in cycle k appears at `o_tx_data` in cycle k+1; all outputs are registered.
- **Reset mid-frame** discards buffered bits; the schedule restarts at `seq` = 0 on the first cycle after reset release.
- **Simultaneous pause and valid** counts as a slip. The drain still occurs that cycle.

## Configuration
- **`PCS_GEARBOX_STATS_EN` defined** adds two ports, each cleared by reset:
  - `o_block_cnt` [31:0]: counts accepted phase-0 words, wraps.
  - `o_err_cnt` [15:0]: counts slip + underrun + header events, saturates at 0xFFFF.
- **`PCS_GEARBOX_STATS_EN` undefined:** the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- **Package `pcs_pkg`:** SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10, GB_SEQ_MAX = 32, GB_BUF_W = 96.
- **Sub-module `pcs_gearbox_seq`:** the slot counter plus TRDY_LEAD look-ahead, producing `seq`, `pause_slot`, and `trdy_next`.

## Test plan
- **Steady stream.** Reset, then send valid words in every data slot with headers alternating 01/10 and data = incrementing index. Required: the output bitstream equals the concatenation hdr,data,data,…; `o_tx_data_valid` = 1 continuously after the first word; no error pulses.
- **Pause alignment.** TRDY_LEAD = 2. Required: `o_tx_trdy` is low for exactly one cycle every 33, and the first pause slot is at cycle 32 after reset release.
- **Slip.** Drive a valid word (data 0xDEADBEEF) in a pause slot. Required: `o_slip_err` pulses once, the word is absent from the output, and `phase` is unchanged.
- **Underrun.** Withhold valid for 3 consecutive data slots. Required: `o_underrun` pulses once buffered bits are exhausted and `o_tx_data_valid` drops; the stream resumes with no lost bits after valid returns.
- **Bad header.** Send header 2'b11 with data 0x0. Required: `o_hdr_err` pulses one cycle and bits 11 appear first in the output word.
- **Reset mid-frame.** Assert reset at `seq` = 17. Required: all outputs return to reset values next cycle; the first post-reset output starts with the first post-reset header bit.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared constants and types for the 10GBASE-R PCS transmit gearbox.
package pcs_pkg;
  localparam logic [1:0] SYNC_DATA  = 2'b01;
  localparam logic [1:0] SYNC_CTRL  = 2'b10;
  localparam int         GB_SEQ_MAX = 32;
  localparam int         GB_BUF_W   = 96;
  localparam int         GB_CNT_W   = 7;
  localparam int         GB_SEQ_W   = 6;

  typedef enum logic {PH_HDR = 1'b0, PH_BODY = 1'b1} gb_phase_e;

  typedef struct packed {
    logic slip;
    logic underrun;
    logic hdr;
  } gb_evt_t;

  function automatic logic hdr_ok(input logic [1:0] h);
    return (h == SYNC_DATA) || (h == SYNC_CTRL);
  endfunction
endpackage

// File: rtl/pcs_gearbox_seq.sv
// Free-running 0..32 slot counter; flags the pause slot and the trdy look-ahead.
module pcs_gearbox_seq
  import pcs_pkg::*;
#(
  parameter int TRDY_LEAD = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_pause_slot,
  output logic o_trdy_next
);
  localparam int NSLOT = GB_SEQ_MAX + 1;
  // trdy is registered, so it must drop one slot before the lead window opens
  localparam int TRDY_LOW_SEQ = (((GB_SEQ_MAX - 1 - TRDY_LEAD) % NSLOT) + NSLOT) % NSLOT;

  logic [GB_SEQ_W-1:0] seq_q, seq_d;

  always_comb begin
    seq_d = (seq_q == GB_SEQ_W'(GB_SEQ_MAX)) ? '0 : seq_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) seq_q <= '0;
    else            seq_q <= seq_d;
  end

  assign o_pause_slot = (seq_q == GB_SEQ_W'(GB_SEQ_MAX));
  assign o_trdy_next  = (seq_q != GB_SEQ_W'(TRDY_LOW_SEQ));
endmodule

// File: rtl/pcs_tx_gearbox.sv
// 66b->64b transmit gearbox packing sync headers and 32-bit words into a 32-bit line stream.
// Define PCS_GEARBOX_STATS_EN to add the o_block_cnt / o_err_cnt statistics ports.
module pcs_tx_gearbox
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TRDY_LEAD  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [1:0]            i_rx_hdr,
  input  logic                  i_rx_data_valid,
  output logic                  o_tx_trdy,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_data_valid,
  output logic                  o_slip_err,
  output logic                  o_underrun,
  output logic                  o_hdr_err
`ifdef PCS_GEARBOX_STATS_EN
  ,
  output logic [31:0]           o_block_cnt,
  output logic [15:0]           o_err_cnt
`endif
);
  logic pause_slot, trdy_next;

  pcs_gearbox_seq #(.TRDY_LEAD(TRDY_LEAD)) u_seq (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .o_pause_slot (pause_slot),
    .o_trdy_next  (trdy_next)
  );

  logic [GB_BUF_W-1:0]   buf_q, buf_d, merged, in_vec;
  logic [GB_CNT_W-1:0]   count_q, count_d, total, in_bits;
  gb_phase_e             phase_q, phase_d;
  logic                  started_q, started_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  trdy_q;
  gb_evt_t               evt_q, evt_d;
  logic                  accept;

  always_comb begin
    accept  = i_rx_data_valid && !pause_slot;
    in_vec  = '0;
    in_bits = '0;
    if (accept) begin
      if (phase_q == PH_HDR) begin
        in_vec  = GB_BUF_W'({i_rx_data, i_rx_hdr});
        in_bits = GB_CNT_W'(DATA_WIDTH + 2);
      end else begin
        in_vec  = GB_BUF_W'(i_rx_data);
        in_bits = GB_CNT_W'(DATA_WIDTH);
      end
    end
    // bits above count are always zero, so OR-ing in the new word appends it
    merged = buf_q | (in_vec << count_q);
    total  = count_q + in_bits;

    buf_d        = buf_q;
    count_d      = count_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    phase_d      = accept ? gb_phase_e'(~phase_q) : phase_q;
    started_d    = started_q | accept;
    evt_d.slip     = i_rx_data_valid && pause_slot;
    evt_d.hdr      = accept && (phase_q == PH_HDR) && !hdr_ok(i_rx_hdr);
    evt_d.underrun = 1'b0;
    if (total >= GB_CNT_W'(DATA_WIDTH)) begin
      tx_data_d  = merged[DATA_WIDTH-1:0];
      tx_valid_d = 1'b1;
      buf_d      = merged >> DATA_WIDTH;
      count_d    = total - GB_CNT_W'(DATA_WIDTH);
    end else begin
      evt_d.underrun = started_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      buf_q      <= '0;
      count_q    <= '0;
      phase_q    <= PH_HDR;
      started_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      trdy_q     <= 1'b1;
      evt_q      <= '0;
    end else begin
      buf_q      <= buf_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      started_q  <= started_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      trdy_q     <= trdy_next;
      evt_q      <= evt_d;
    end
  end

  assign o_tx_trdy       = trdy_q;
  assign o_tx_data       = tx_data_q;
  assign o_tx_data_valid = tx_valid_q;
  assign o_slip_err      = evt_q.slip;
  assign o_underrun      = evt_q.underrun;
  assign o_hdr_err       = evt_q.hdr;

`ifdef PCS_GEARBOX_STATS_EN
  logic [31:0] block_cnt_q, block_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    logic [17:0] sum;
    block_cnt_d = block_cnt_q + ((accept && (phase_q == PH_HDR)) ? 32'd1 : 32'd0);
    sum = {2'b00, err_cnt_q} + 18'(evt_d.slip) + 18'(evt_d.underrun) + 18'(evt_d.hdr);
    err_cnt_d = (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      block_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      block_cnt_q <= block_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_block_cnt = block_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`endif
endmodule
